rowbuffer_drain: RTL and testbench



---
 rtl/rowbuffer_drain.sv | 101 ++++++++++
 tb/tb_rowbuffer_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rowbuffer_drain.sv
// Streams aggregated rows out of the idle row-buffer bank, one wide beat per cycle,
// through a two-entry skid FIFO that covers the one-cycle RAM read latency.
module rowbuffer_drain #(
  parameter int dataWidth = 32,
  parameter int pvadd = 128,
  parameter int k = 1024,
  localparam int W = dataWidth * pvadd,
  localparam int AW = $clog2(k),
  localparam int CW = $clog2(k + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] row_count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for start
  // DRAIN | issuing reads and streaming beats
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FIN = 2'd2} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] rows, issued, sent;
  logic          inflight;
  logic [1:0]    fifoCount;
  logic          wrPtr, rdPtr;
  logic [W-1:0]  mem [2];
  logic          startAcc, pop;

  assign startAcc  = start && (state == IDLE);
  assign out_valid = (fifoCount != 2'd0);
  assign out_data  = mem[rdPtr];
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (sent == rows - CW'(1));
  assign busy      = (state == DRAIN);
  assign done      = (state == FIN);
  assign rd_addr   = issued[AW-1:0];

  // Only issue a read if the FIFO is guaranteed a free slot when the data lands.
  assign rd_en = (state == DRAIN) && (issued < rows) &&
                 (({1'b0, fifoCount} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startAcc) stateNext = (row_count == '0) ? FIN : DRAIN;
      DRAIN:   if (pop && out_last) stateNext = FIN;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows      <= '0;
      issued    <= '0;
      sent      <= '0;
      inflight  <= 1'b0;
      fifoCount <= 2'd0;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      if (startAcc) begin
        rows   <= row_count;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (rd_en) issued <= issued + CW'(1);
        if (pop)   sent   <= sent + CW'(1);
      end
      inflight <= rd_en;
      if (inflight) begin
        mem[wrPtr] <= rd_data;
        wrPtr      <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCount <= fifoCount + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(inflight && !pop && (fifoCount == 2'd2)));

endmodule

// File: tb/tb_rowbuffer_drain.sv
// Randomized bench for rowbuffer_drain: a behavioural RAM plus an in-order expected
// row stream and cycle timing derived from the block's latency rules.
module tb_rowbuffer_drain;
  localparam int dataWidth = 32;
  localparam int pvadd = 128;
  localparam int k = 1024;
  localparam int W = dataWidth * pvadd;
  localparam int AW = $clog2(k);
  localparam int CW = $clog2(k + 1);

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [CW-1:0] row_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data, out_data;
  logic          out_valid, out_last, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rowbuffer_drain #(.dataWidth(dataWidth), .pvadd(pvadd), .k(k)) dut (
    .clk(clk), .rst(rst), .start(start), .row_count(row_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] rowVal(input int i);
    logic [W-1:0] r;
    for (int j = 0; j < pvadd; j++) r[j*dataWidth +: dataWidth] = dataWidth'(i);
    return r;
  endfunction

  // Row buffer: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? rowVal(int'(rd_addr)) : '1;

  logic [W-1:0] gotData[$];
  int beatRel[$];
  int reads, pops, maxOut, doneRel, firstRdRel, addrErr, holdErr, lastErr, busyErr;
  int stallRd, outAtStallEnd, validSeen;
  bit timedOut, aborted;

  // Runs one block and records what the DUT did; cycle 0 is the start cycle.
  task automatic runBlock(input int n, input int readyPct, input int stallFrom,
                          input int stallLen, input int secondAt, input int abortBeat,
                          input int budget);
    logic [W-1:0] prevData;
    bit prevHold, inStall;
    int outNow;
    gotData.delete(); beatRel.delete();
    reads = 0; pops = 0; maxOut = 0; doneRel = -1; firstRdRel = -1;
    addrErr = 0; holdErr = 0; lastErr = 0; busyErr = 0; stallRd = 0;
    outAtStallEnd = -1; validSeen = 0; timedOut = 1; aborted = 0;
    prevHold = 0; prevData = '0;
    @(posedge clk); #1;
    start = 1'b1; row_count = CW'(n); out_ready = 1'b1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(posedge clk); #1;
      start = (rel == secondAt);
      if (rel == secondAt) row_count = CW'(2);
      inStall = (rel >= stallFrom) && (rel < stallFrom + stallLen);
      out_ready = inStall ? 1'b0 : (int'($urandom_range(99)) < readyPct);
      #1;
      if (abortBeat >= 0 && out_valid && gotData.size() == abortBeat) begin
        aborted = 1; timedOut = 0;
        return;
      end
      outNow = reads - pops;
      if (outNow > maxOut) maxOut = outNow;
      if (rd_en) begin
        if (firstRdRel < 0) firstRdRel = rel;
        if (rd_addr !== AW'(reads % k)) addrErr++;
        if (inStall && rel > stallFrom) stallRd++;
        reads++;
      end
      if (out_valid) begin
        validSeen++;
        if (prevHold && out_data !== prevData) holdErr++;
        if (out_last !== (gotData.size() == n - 1)) lastErr++;
        if (out_ready) begin
          gotData.push_back(out_data); beatRel.push_back(rel); pops++;
        end
        prevHold = !out_ready; prevData = out_data;
      end else begin
        if (prevHold) holdErr++;
        if (out_last) lastErr++;
        prevHold = 0;
      end
      if (stallLen > 0 && rel == stallFrom + stallLen - 1) outAtStallEnd = reads - pops;
      if (done) begin
        doneRel = rel;
        if (busy) busyErr++;
        timedOut = 0;
        return;
      end
      if (n > 0 && busy !== 1'b1) busyErr++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {rd_en, out_valid, out_last, busy, done});
    end
    checks++;
    if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", out_data[31:0]); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    runBlock(4, 100, 0, 0, -1, -1, 40);
    checks++;
    if (timedOut) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++;
    if (firstRdRel !== 1) begin errors++; $display("FAIL basic_first_rd got=%0d exp=1", firstRdRel); end
    checks++;
    if (gotData.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", gotData.size()); end
    for (int i = 0; i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] !== rowVal(i) || beatRel[i] !== 3 + i) begin
        errors++;
        $display("FAIL basic_beat%0d got=%0h@%0d exp=%0h@%0d", i, gotData[i][31:0], beatRel[i], i, 3 + i);
      end
    end
    checks++;
    if (lastErr !== 0) begin errors++; $display("FAIL basic_last errors got=%0d exp=0", lastErr); end
    checks++;
    if (doneRel !== 7) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=7", doneRel); end
    checks++;
    if (busyErr !== 0 || addrErr !== 0) begin
      errors++; $display("FAIL basic_busy_addr got=%0d/%0d exp=0/0", busyErr, addrErr);
    end
  endtask

  task automatic test_back_to_back;
    runBlock(3, 100, 0, 0, -1, -1, 40);
    checks++;
    if (doneRel !== 6) begin errors++; $display("FAIL b2b_first_done got=%0d exp=6", doneRel); end
    start = 1'b1; row_count = CW'(7);
    runBlock(2, 100, 0, 0, -1, -1, 40);
    checks++;
    if (gotData.size() !== 2 || doneRel !== 5) begin
      errors++; $display("FAIL b2b_second got=%0d beats done@%0d exp=2 beats done@5", gotData.size(), doneRel);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] !== rowVal(i)) begin
        errors++; $display("FAIL b2b_beat%0d got=%0h exp=%0h", i, gotData[i][31:0], i);
      end
    end
  endtask

  task automatic test_zero_rows;
    runBlock(0, 100, 0, 0, -1, -1, 20);
    checks++;
    if (doneRel !== 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", doneRel); end
    checks++;
    if (reads !== 0 || validSeen !== 0) begin
      errors++; $display("FAIL zero_activity got=%0d reads %0d valid exp=0 0", reads, validSeen);
    end
    checks++;
    if (busyErr !== 0) begin errors++; $display("FAIL zero_busy got=%0d exp=0", busyErr); end
  endtask

  task automatic test_stall;
    runBlock(8, 100, 2, 10, -1, -1, 60);
    checks++;
    if (outAtStallEnd !== 2) begin errors++; $display("FAIL stall_buffered got=%0d exp=2", outAtStallEnd); end
    checks++;
    if (stallRd !== 0) begin errors++; $display("FAIL stall_rd_en got=%0d exp=0", stallRd); end
    checks++;
    if (holdErr !== 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0", holdErr); end
    checks++;
    if (gotData.size() !== 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", gotData.size()); end
    for (int i = 0; i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] !== rowVal(i) || beatRel[i] !== 12 + i) begin
        errors++;
        $display("FAIL stall_beat%0d got=%0h@%0d exp=%0h@%0d", i, gotData[i][31:0], beatRel[i], i, 12 + i);
      end
    end
    checks++;
    if (doneRel !== 20) begin errors++; $display("FAIL stall_done got=%0d exp=20", doneRel); end
  endtask

  task automatic test_second_start;
    runBlock(5, 100, 0, 0, 2, -1, 40);
    checks++;
    if (gotData.size() !== 5 || doneRel !== 8) begin
      errors++; $display("FAIL second_start got=%0d beats done@%0d exp=5 beats done@8", gotData.size(), doneRel);
    end
    checks++;
    if (lastErr !== 0) begin errors++; $display("FAIL second_start_last got=%0d exp=0", lastErr); end
  endtask

  task automatic test_reset_abort;
    int doneSeen;
    runBlock(6, 100, 0, 0, -1, 2, 40);
    checks++;
    if (!aborted) begin errors++; $display("FAIL abort_reach_beat2 got=0 exp=1"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en, out_valid, out_last, busy, done} !== 5'b0 || out_data !== '0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL abort_outputs got=%b data=%0h addr=%0d exp=00000 0 0",
               {rd_en, out_valid, out_last, busy, done}, out_data[31:0], rd_addr);
    end
    doneSeen = 0;
    repeat (2) begin @(posedge clk); #1; if (done) doneSeen++; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done || out_valid) doneSeen++; end
    checks++;
    if (doneSeen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", doneSeen); end
    runBlock(2, 100, 0, 0, -1, -1, 40);
    checks++;
    if (gotData.size() !== 2 || doneRel !== 5) begin
      errors++; $display("FAIL abort_next got=%0d beats done@%0d exp=2 beats done@5", gotData.size(), doneRel);
    end
    for (int i = 0; i < gotData.size(); i++) begin
      checks++;
      if (gotData[i] !== rowVal(i)) begin
        errors++; $display("FAIL abort_next_beat%0d got=%0h exp=%0h", i, gotData[i][31:0], i);
      end
    end
  endtask

  task automatic test_random;
    int n, pct, bad;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(20, 1));
      pct = int'($urandom_range(100, 30));
      runBlock(n, pct, 0, 0, -1, -1, 400);
      bad = 0;
      for (int i = 0; i < gotData.size(); i++) if (gotData[i] !== rowVal(i)) bad++;
      checks++;
      if (timedOut || gotData.size() !== n || bad !== 0) begin
        errors++;
        $display("FAIL random%0d got=%0d beats %0d bad to=%0d exp=%0d beats 0 bad", it, gotData.size(), bad, timedOut, n);
      end
      checks++;
      if (maxOut > 2 || lastErr !== 0 || holdErr !== 0 || addrErr !== 0) begin
        errors++;
        $display("FAIL random%0d_proto got=out%0d last%0d hold%0d addr%0d exp=<=2 0 0 0", it, maxOut, lastErr, holdErr, addrErr);
      end
    end
  endtask

  task automatic test_full_block;
    int bad;
    runBlock(k, 50, 0, 0, -1, -1, 20000);
    checks++;
    if (timedOut) begin errors++; $display("FAIL full_timeout got=1 exp=0"); end
    checks++;
    if (gotData.size() !== k || reads !== k) begin
      errors++; $display("FAIL full_count got=%0d beats %0d reads exp=%0d", gotData.size(), reads, k);
    end
    bad = 0;
    for (int i = 0; i < gotData.size(); i++) if (gotData[i] !== rowVal(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_order got=%0d bad beats exp=0", bad); end
    checks++;
    if (maxOut > 2) begin errors++; $display("FAIL full_fifo_depth got=%0d exp=<=2", maxOut); end
    checks++;
    if (addrErr !== 0 || lastErr !== 0 || holdErr !== 0) begin
      errors++; $display("FAIL full_proto got=addr%0d last%0d hold%0d exp=0 0 0", addrErr, lastErr, holdErr);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; row_count = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_zero_rows;
    test_stall;
    test_second_start;
    test_reset_abort;
    test_random;
    test_full_block;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
